// File: rtl/chunked_mem_ctrl.sv
// Single-port word memory written through a narrow chunked bus and read via a valid/ready response.
// Optional MEM_CLEAR_EN: zero-fill sweep of the whole array after every reset release.
module chunked_mem_ctrl #(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned CHUNK_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [CHUNK_W-1:0] wd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    localparam int unsigned NUM_CHUNKS = DATA_W / CHUNK_W;
    localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int unsigned DEPTH      = 2 ** ADDR_W;

    generate
        if ((DATA_W % CHUNK_W) != 0 || NUM_CHUNKS == 0) begin : g_bad_chunk
            $error("chunked_mem_ctrl: DATA_W must be an integer multiple of CHUNK_W");
        end
    endgenerate

`ifdef MEM_CLEAR_EN
    typedef enum logic [1:0] {IDLE = 2'd0, WR_DATA = 2'd1, RD_RESP = 2'd2, CLEAR = 2'd3} state_t;
    localparam state_t RST_STATE = CLEAR;
    localparam logic   RST_READY = 1'b0;
    logic [ADDR_W-1:0] r_clr_cnt;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, WR_DATA = 2'd1, RD_RESP = 2'd2} state_t;
    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_READY = 1'b1;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_cmd_ready;
    logic                r_wd_ready;
    logic                r_rd_valid;
    logic                r_busy;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic [DATA_W-1:0]   r_shadow;
    logic [DATA_W-1:0]   r_rd_data;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_wr_last;
    logic [DATA_W-1:0]   w_wr_word;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;

    assign cmd_ready = r_cmd_ready;
    assign wd_ready  = r_wd_ready;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign busy      = r_busy;

    assign w_wr_last = (r_beat_cnt == CNT_W'(NUM_CHUNKS - 1));

    // Shadow word with the incoming chunk merged in at the current beat position
    always_comb begin
        w_wr_word = r_shadow;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (r_beat_cnt == CNT_W'(i)) begin
                w_wr_word[i*CHUNK_W +: CHUNK_W] = wd_data;
            end
        end
    end

    // State register; handshake outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RST_STATE;
            r_cmd_ready <= RST_READY;
            r_wd_ready  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_busy      <= ~RST_READY;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == IDLE);
            r_wd_ready  <= (w_state_nxt == WR_DATA);
            r_rd_valid  <= (w_state_nxt == RD_RESP);
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (cmd_valid) w_state_nxt = cmd_write ? WR_DATA : RD_RESP;
            WR_DATA: if (wd_valid && w_wr_last) w_state_nxt = IDLE;
            RD_RESP: if (rd_ready) w_state_nxt = IDLE;
`ifdef MEM_CLEAR_EN
            CLEAR:   if (r_clr_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = IDLE;
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // Memory write port: chunk commit, or zero-fill during the clear sweep
    always_comb begin
        w_mem_we    = (r_state == WR_DATA) && wd_valid && w_wr_last;
        w_mem_addr  = r_addr;
        w_mem_wdata = w_wr_word;
`ifdef MEM_CLEAR_EN
        if (r_state == CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_cnt;
            w_mem_wdata = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_beat_cnt <= '0;
            r_shadow   <= '0;
            r_rd_data  <= '0;
`ifdef MEM_CLEAR_EN
            r_clr_cnt  <= '0;
`endif
        end else begin
            if (r_state == IDLE && cmd_valid) begin
                if (cmd_write) begin
                    r_addr     <= cmd_addr;
                    r_beat_cnt <= '0;
                end else begin
                    r_rd_data  <= r_mem[cmd_addr];
                end
            end
            if (r_state == WR_DATA && wd_valid) begin
                r_shadow   <= w_wr_word;
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
`ifdef MEM_CLEAR_EN
            if (r_state == CLEAR) begin
                r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_chunked_mem_ctrl.sv
// Directed bench for chunked_mem_ctrl at default parameters; covers MEM_CLEAR_EN when defined.
module tb_chunked_mem_ctrl;

    localparam int unsigned DATA_W  = 12;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned CHUNK_W = 6;
`ifdef MEM_CLEAR_EN
    localparam logic CLR = 1'b1;
`else
    localparam logic CLR = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_write;
    logic [ADDR_W-1:0]  cmd_addr;
    logic               wd_valid;
    logic               wd_ready;
    logic [CHUNK_W-1:0] wd_data;
    logic               rd_valid;
    logic               rd_ready;
    logic [DATA_W-1:0]  rd_data;
    logic               busy;

    int n_vec = 0;
    int n_err = 0;

    chunked_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CHUNK_W(CHUNK_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (cmd_ready !== 1'b1 && k < 5000) begin
            tick();
            k++;
        end
        chk("ready_wait", 32'(cmd_ready), 32'd1);
    endtask

    task automatic write_cmd(input logic [ADDR_W-1:0] a);
        chk("wr_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a;
        tick();
        cmd_valid = 1'b0;
        chk("wr_wd_ready", 32'(wd_ready), 32'd1);
    endtask

    task automatic beat(input logic [CHUNK_W-1:0] d);
        wd_valid = 1'b1; wd_data = d;
        tick();
        wd_valid = 1'b0;
    endtask

    task automatic read_chk(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        chk("rd_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a;
        tick();
        cmd_valid = 1'b0;
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk("rd_data", 32'(rd_data), 32'(exp));
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("rd_done_valid", 32'(rd_valid), 32'd0);
        chk("rd_done_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0;
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(!CLR));
        chk("rst_busy", 32'(busy), 32'(CLR));
        chk("rst_wd_ready", 32'(wd_ready), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        tick();
        rst_n = 1'b1;

`ifdef MEM_CLEAR_EN
        begin
            int k = 0;
            while (cmd_ready !== 1'b1 && k < 5000) begin
                tick();
                k++;
            end
            chk("clear_cycles", 32'(k), 32'd1024);
        end
        read_chk(10'h000, 12'h000);
        read_chk(10'h2AB, 12'h000);
        read_chk(10'h3FF, 12'h000);
`endif

        // Basic two-beat write, LS chunk first
        write_cmd(10'h005); beat(6'h2A); beat(6'h15);
        chk("wr_done_ready", 32'(cmd_ready), 32'd1);
        read_chk(10'h005, 12'h56A);

        // Top address and address zero do not alias
        write_cmd(10'h3FF); beat(6'h3F); beat(6'h3F);
        write_cmd(10'h000); beat(6'h01); beat(6'h00);
        read_chk(10'h3FF, 12'hFFF);
        read_chk(10'h000, 12'h001);

        // Gap between beats; a read offered mid-write is not accepted
        write_cmd(10'h010); beat(6'h11);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h010;
        for (int i = 0; i < 4; i++) begin
            chk("gap_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("gap_busy", 32'(busy), 32'd1);
            chk("gap_rd_valid", 32'(rd_valid), 32'd0);
            tick();
        end
        cmd_valid = 1'b0;
        beat(6'h22);
        read_chk(10'h010, 12'h891);

        // Read backpressure holds the response stable
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h3FF;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_rd_valid", 32'(rd_valid), 32'd1);
            chk("bp_rd_data", 32'(rd_data), 32'hFFF);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            tick();
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("bp_done_valid", 32'(rd_valid), 32'd0);
        chk("bp_done_ready", 32'(cmd_ready), 32'd1);

        // Reset mid-write discards the partial word
        write_cmd(10'h005); beat(6'h3F);
        rst_n = 1'b0;
        #2;
        chk("mw_rst_busy", 32'(busy), 32'(CLR));
        chk("mw_rst_wd_ready", 32'(wd_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        wait_ready();
        read_chk(10'h005, CLR ? 12'h000 : 12'h56A);

        // Reset mid-read drops the response
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h000;
        tick();
        cmd_valid = 1'b0;
        chk("mr_rd_valid", 32'(rd_valid), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("mr_rst_rd_valid", 32'(rd_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        wait_ready();
        chk("mr_after_rd_valid", 32'(rd_valid), 32'd0);

        // Stray write-data beats in IDLE are ignored
        wd_valid = 1'b1; wd_data = 6'h2A;
        tick();
        wd_valid = 1'b0;
        chk("stray_wd_ready", 32'(wd_ready), 32'd0);
        chk("stray_busy", 32'(busy), 32'd0);
        write_cmd(10'h200); beat(6'h07); beat(6'h38);
        read_chk(10'h200, 12'hE07);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/chunked_mem_ctrl.md
Name: chunked_mem_ctrl

Overview:
Parametrised single-port word memory behind a narrow write bus, for blocks whose data bus is narrower than the memory word. A write is one address beat followed by NUM_CHUNKS data beats. These are assembled in a shadow register and committed atomically on the last beat, so a partial word is never visible. Reads return a full word one cycle after acceptance through a valid/ready response channel with backpressure. It sits between the instruction/data sequencer and storage.

Parameters:
DATA_W, 12, memory word width in bits
ADDR_W, 10, address width; depth = 2**ADDR_W words
CHUNK_W, 6, write-bus width; DATA_W must be an integer multiple of CHUNK_W (elaboration error otherwise)
NUM_CHUNKS (localparam), DATA_W/CHUNK_W, data beats per write

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write transaction, 0 = read
cmd_addr  in  ADDR_W  word address
wd_valid  in  1  write-data beat offered
wd_ready  out  1  beat accepted when wd_valid & wd_ready
wd_data  in  CHUNK_W  write chunk, least-significant chunk first
rd_valid  out  1  read response valid
rd_ready  in  1  read response consumed when rd_valid & rd_ready
rd_data  out  DATA_W  read word
busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cmd_ready=1 (0 if MEM_CLEAR_EN, see below), wd_ready=0, rd_valid=0, rd_data=0, busy=0, beat counter=0, shadow=0. Memory array contents are not reset.
- States: IDLE, WR_DATA, RD_RESP (plus CLEAR with MEM_CLEAR_EN).
- IDLE:
  - cmd_ready=1.
  - On accepted write: latch cmd_addr, beat_cnt=0, go to WR_DATA.
  - On accepted read: register rd_data=mem[cmd_addr] at that edge, rd_valid=1 next cycle, go to RD_RESP.
  - cmd_write and cmd_addr are ignored when cmd_valid=0.
- WR_DATA:
  - cmd_ready=0, wd_ready=1.
  - Each accepted beat writes shadow[beat_cnt*CHUNK_W +: CHUNK_W] and increments beat_cnt.
  - Idle cycles between beats (wd_valid=0) are allowed and change nothing.
  - On the beat where beat_cnt==NUM_CHUNKS-1: at that same edge, mem[addr] = assembled word (shadow with final chunk merged); return to IDLE; cmd_ready=1 the next cycle.
  - NUM_CHUNKS=1: commit on the first beat.
- RD_RESP:
  - rd_valid=1; rd_data is held stable until the handshake.
  - On rd_valid&rd_ready: rd_valid=0 next cycle, return to IDLE.
  - rd_data keeps its last value after the handshake; it is only defined while rd_valid=1.
- wd_valid outside WR_DATA is ignored (wd_ready=0).
- Commands are fully serialised, so there are no read/write hazards. A read issued after a write commit returns the new data.
- Latency:
  - Write: 1 + NUM_CHUNKS handshakes minimum; default params is 3 cycles back-to-back.
  - Read: response valid the cycle after command acceptance.
- Addresses span the full 0..2**ADDR_W-1 range. There is no wrap or aliasing, and the top address 2**ADDR_W-1 is valid.
- Reset mid-write: partial shadow is discarded, the target word is unchanged, and the FSM returns to IDLE.
- Reset mid-read: the response is dropped (rd_valid=0).

Optional Feature:
MEM_CLEAR_EN
- Defined:
  - After rst_n deasserts, FSM starts in CLEAR and writes 0 to addresses 0..2**ADDR_W-1, one per cycle, ascending.
  - During CLEAR: cmd_ready=0 and busy=1.
  - After the last address, state goes to IDLE; cmd_ready=1 on cycle 2**ADDR_W+1 after reset release.
  - Reset during CLEAR restarts the sweep from 0.
- Not defined: no CLEAR state; FSM starts in IDLE and memory contents are undefined until written.

Test Plan:
- Write addr 0x005, beats 0x2A then 0x15 -> after the last beat, read 0x005 gives rd_valid one cycle after acceptance with rd_data=0x56A.
- Write addr 0x3FF with beats 0x3F,0x3F, then write 0x000 with beats 0x01,0x00 -> read 0x3FF gives 0xFFF and read 0x000 gives 0x001 (no aliasing at the top address).
- Write 0x010 with beat 0x11, wd_valid low for 4 cycles, then beat 0x22 -> read 0x010 gives 0x891. A read of 0x010 before the second beat is impossible: cmd_ready=0 and busy=1 throughout.
- Read with rd_ready held low for 3 cycles -> rd_valid and rd_data stay stable for all 3 cycles; after the handshake, rd_valid=0 and cmd_ready=1 on the next cycle.
- Write 0x005=0x56A. Start a write to 0x005 with beat 0x3F, then pulse rst_n low -> a subsequent read of 0x005 still gives 0x56A.
- With MEM_CLEAR_EN and default params: release reset -> cmd_ready=0 for 1024 cycles, then 1. A read of any address (0x000, 0x2AB, 0x3FF) gives 0x000.
